// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit
//   Instruction-fetch stage for the 5-stage RISC-V pipeline. Owns the PC, issues
//   word reads over a req/gnt + rvalid handshake, keeps returned words in a small
//   in-order prefetch FIFO and loads one instruction per cycle into IF/ID.
//   Supports hazard stall (IF/ID frozen) and branch/jump redirect (flush and
//   refetch, with responses already in flight silently discarded).
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   stall                  hold IF/ID, no FIFO pop
//   redirect, redirect_pc  restart fetch at redirect_pc (low two bits forced 0)
//   imem_req, imem_addr    fetch request / word-aligned byte address
//   imem_gnt               request accepted this cycle
//   imem_rvalid, imem_rdata in-order read response
//   ifid_ir, ifid_pc       IF/ID instruction and its PC
//   ifid_valid             1 = real instruction, 0 = NOP bubble
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] fifo_rd, fifo_wr;
  logic [PW-1:0] aq_rd, aq_wr;
  logic [31:0]   fifo_ir [DEPTH];
  logic [31:0]   fifo_pc [DEPTH];
  logic [31:0]   aq      [DEPTH];

  logic [CW:0] occupancy;
  logic        fire, resp, resp_drop, resp_keep;
  logic        fifo_empty, do_pop, do_push, bypass;

  // A slot is reserved for every request in flight, so a response always
  // finds room in the FIFO.
  assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req  = !reset && (occupancy < LIMIT) && !redirect;
  assign imem_addr = pc;
  assign fire      = imem_req && imem_gnt;

  // A response with nothing outstanding (e.g. one issued before a reset) is ignored.
  assign resp      = imem_rvalid && (outstanding != '0);
  assign resp_drop = resp && (drop != '0);
  assign resp_keep = resp && (drop == '0);

  assign fifo_empty = (fifo_count == '0);
  assign do_pop     = !redirect && !stall && !fifo_empty;
  assign bypass     = resp_keep && fifo_empty && !stall && !redirect;
  assign do_push    = resp_keep && !bypass && !redirect;

  // PC, in-flight accounting and the in-flight address queue. Dropped responses
  // still consume their address queue entry, so the queue is never flushed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      aq_rd       <= '0;
      aq_wr       <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(resp);
      if (redirect) begin
        pc   <= redirect_pc & ~32'd3;
        drop <= outstanding + CW'(fire) - CW'(resp);
      end else begin
        if (fire)      pc   <= pc + 32'd4;
        if (resp_drop) drop <= drop - CW'(1);
      end
      if (fire) aq_wr <= aq_wr + PW'(1);
      if (resp) aq_rd <= aq_rd + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (fire) aq[aq_wr] <= pc;
  end

  // Prefetch FIFO pointers/count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_rd    <= '0;
      fifo_wr    <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      fifo_wr    <= fifo_rd;
      fifo_count <= '0;
    end else begin
      if (do_push) fifo_wr <= fifo_wr + PW'(1);
      if (do_pop)  fifo_rd <= fifo_rd + PW'(1);
      fifo_count <= fifo_count + CW'(do_push) - CW'(do_pop);
    end
  end

  // On a full FIFO a same-cycle push reuses the slot being popped; the pop reads
  // the old contents because both use the pre-edge value.
  always_ff @(posedge clock) begin
    if (do_push) begin
      fifo_ir[fifo_wr] <= imem_rdata;
      fifo_pc[fifo_wr] <= aq[aq_rd];
    end
  end

  // IF/ID register: redirect > stall > FIFO head > bypassed response > bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ifid_ir    <= NOP;
      ifid_pc    <= RESET_PC;
      ifid_valid <= 1'b0;
    end else if (redirect) begin
      ifid_ir    <= NOP;
      ifid_valid <= 1'b0;
    end else if (stall) begin
      ifid_ir    <= ifid_ir;
      ifid_valid <= ifid_valid;
    end else if (!fifo_empty) begin
      ifid_ir    <= fifo_ir[fifo_rd];
      ifid_pc    <= fifo_pc[fifo_rd];
      ifid_valid <= 1'b1;
    end else if (bypass) begin
      ifid_ir    <= imem_rdata;
      ifid_pc    <= aq[aq_rd];
      ifid_valid <= 1'b1;
    end else begin
      ifid_ir    <= NOP;
      ifid_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Testbench for riscv_fetch_unit: directed scenarios plus randomized stall,
// redirect, grant, latency and reset traffic. Expected IF/ID contents come from a
// program-order reference stream; a negedge monitor pops and compares.
module tb_riscv_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ifid_ir;
  logic [31:0] ifid_pc;
  logic        ifid_valid;

  riscv_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2), .NOP(NOP)) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifid_ir(ifid_ir), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned nvalid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every address holds a distinct word (odd multiplier is a bijection)
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory model ----------------
  typedef struct { logic [31:0] addr; int unsigned ready; } req_t;
  req_t mq[$];
  int unsigned cyc = 0;
  int unsigned lat_min = 1, lat_max = 1;
  bit rv_q = 1'b0;
  bit late_pending = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      if (mq.size() != 0) late_pending = 1'b1;
      mq.delete();
    end else begin
      if (imem_rvalid && rv_q) void'(mq.pop_front());
      if (imem_req && imem_gnt)
        mq.push_back('{addr: imem_addr, ready: cyc + $urandom_range(lat_max, lat_min)});
    end
  end

  // ---------------- driver ----------------
  bit          k_reset = 1'b1, k_stall = 1'b0, k_redir = 1'b0, k_gnt = 1'b1;
  logic [31:0] k_rpc = '0;

  task automatic step();
    @(posedge clock);
    #1;
    reset       = k_reset;
    stall       = k_stall;
    redirect    = k_redir;
    redirect_pc = k_rpc;
    imem_gnt    = k_gnt;
    rv_q        = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!k_reset) begin
      if (late_pending) begin
        imem_rvalid  = 1'b1;
        late_pending = 1'b0;
      end else if (mq.size() > 0 && mq[0].ready <= cyc + 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mq[0].addr);
        rv_q        = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset(input int unsigned n);
    k_reset = 1'b1; k_stall = 1'b0; k_redir = 1'b0; k_gnt = 1'b1;
    repeat (n) step();
    k_reset = 1'b0;
  endtask

  // ---------------- reference stream + monitor ----------------
  typedef struct { logic [31:0] pc; logic [31:0] ir; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] cursor = RESET_PC;
  logic [31:0] m_ir = NOP, m_pc = RESET_PC;
  logic        m_valid = 1'b0;
  bit          e_stall = 1'b0, e_redir = 1'b0;
  logic [31:0] e_rpc = '0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      cursor  = RESET_PC;
      m_ir    = NOP; m_pc = RESET_PC; m_valid = 1'b0;
      e_stall = 1'b0; e_redir = 1'b0; prev_wait = 1'b0;
      chk("reset_req", {31'd0, imem_req}, 32'd0);
    end else begin
      if (e_redir) begin
        exp_q.delete();
        cursor  = e_rpc & ~32'd3;
        m_ir    = NOP;
        m_valid = 1'b0;
      end else if (e_stall) begin
        // IF/ID held
      end else if (ifid_valid) begin
        while (exp_q.size() < 4) begin
          exp_q.push_back('{pc: cursor, ir: mem_word(cursor)});
          cursor += 32'd4;
        end
        e       = exp_q.pop_front();
        m_ir    = e.ir;
        m_pc    = e.pc;
        m_valid = 1'b1;
        nvalid++;
      end else begin
        m_ir    = NOP;
        m_valid = 1'b0;
      end
      if (imem_req) chk("addr_align", imem_addr & 32'd3, 32'd0);
      if (prev_wait && !redirect) begin
        chk("wait_req", {31'd0, imem_req}, 32'd1);
        chk("wait_addr", imem_addr, prev_addr);
      end
      prev_wait = imem_req && !imem_gnt;
      prev_addr = imem_addr;
      e_stall   = stall;
      e_redir   = redirect;
      e_rpc     = redirect_pc;
    end
    chk("ifid_ir", ifid_ir, m_ir);
    chk("ifid_pc", ifid_pc, m_pc);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: cursor, ir: mem_word(cursor)});
      cursor += 32'd4;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // 1: back-to-back fetch with 1-cycle memory
    lat_min = 1; lat_max = 1;
    do_reset(3);
    step(); chk("t1_req0", {31'd0, imem_req}, 32'd1); chk("t1_addr0", imem_addr, RESET_PC);
    step(); chk("t1_addr1", imem_addr, RESET_PC + 4); chk("t1_valid1", {31'd0, ifid_valid}, 32'd0);
    step(); chk("t1_addr2", imem_addr, RESET_PC + 8); chk("t1_valid2", {31'd0, ifid_valid}, 32'd1);
            chk("t1_pc2", ifid_pc, RESET_PC);
    step(); chk("t1_addr3", imem_addr, RESET_PC + 12); chk("t1_pc3", ifid_pc, RESET_PC + 4);
    step(); chk("t1_pc4", ifid_pc, RESET_PC + 8); chk("t1_valid4", {31'd0, ifid_valid}, 32'd1);

    // 2: stall for 3 edges while IF/ID holds PC 4
    do_reset(2);
    repeat (3) step();
    k_stall = 1'b1;
    step(); chk("t2_pc_a", ifid_pc, RESET_PC + 4);
    step(); chk("t2_pc_b", ifid_pc, RESET_PC + 4); chk("t2_req_drop", {31'd0, imem_req}, 32'd0);
    step(); chk("t2_pc_c", ifid_pc, RESET_PC + 4);
    k_stall = 1'b0;
    step(); chk("t2_pc_d", ifid_pc, RESET_PC + 4);
    step(); chk("t2_next", ifid_pc, RESET_PC + 8); chk("t2_next_v", {31'd0, ifid_valid}, 32'd1);
    step(); chk("t2_next2", ifid_pc, RESET_PC + 12);

    // 3: redirect with two fetches in flight, 3-cycle latency
    lat_min = 3; lat_max = 3;
    do_reset(2);
    step(); step();
    k_redir = 1'b1; k_rpc = 32'h40;
    step(); chk("t3_req_redir", {31'd0, imem_req}, 32'd0);
    k_redir = 1'b0;
    for (int i = 0; i < 20 && !ifid_valid; i++) step();
    chk("t3_first_v", {31'd0, ifid_valid}, 32'd1);
    chk("t3_first_pc", ifid_pc, 32'h40);
    step(); chk("t3_second_pc", ifid_pc, 32'h44);

    // 4: redirect and stall together, unaligned target
    lat_min = 1; lat_max = 1;
    do_reset(2);
    repeat (4) step();
    k_stall = 1'b1; k_redir = 1'b1; k_rpc = 32'h43;
    step();
    k_stall = 1'b0; k_redir = 1'b0;
    step();
    chk("t4_valid", {31'd0, ifid_valid}, 32'd0);
    chk("t4_ir", ifid_ir, NOP);
    chk("t4_addr", imem_addr, 32'h40);
    for (int i = 0; i < 10 && !ifid_valid; i++) step();
    chk("t4_first_pc", ifid_pc, 32'h40);

    // 5: grant withheld for 4 cycles
    do_reset(2);
    step(); step();
    k_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_req", {31'd0, imem_req}, 32'd1);
      chk("t5_addr", imem_addr, RESET_PC + 8);
    end
    k_gnt = 1'b1;
    step(); chk("t5_addr_gnt", imem_addr, RESET_PC + 8);
    step(); chk("t5_addr_next", imem_addr, RESET_PC + 12);

    // 6: reset with a response outstanding, late response after release
    do_reset(2);
    repeat (5) step();
    k_reset = 1'b1;
    step();
    chk("t6_req", {31'd0, imem_req}, 32'd0);
    chk("t6_valid", {31'd0, ifid_valid}, 32'd0);
    chk("t6_ir", ifid_ir, NOP);
    chk("t6_pc", ifid_pc, RESET_PC);
    step();
    k_reset = 1'b0;
    step();
    chk("t6_restart_addr", imem_addr, RESET_PC);
    for (int i = 0; i < 10 && !ifid_valid; i++) step();
    chk("t6_first_pc", ifid_pc, RESET_PC);

    // Randomized traffic
    lat_min = 1; lat_max = 4;
    do_reset(2);
    nvalid = 0;
    for (int i = 0; i < 1500; i++) begin
      k_stall = ($urandom_range(99) < 25);
      k_redir = ($urandom_range(99) < 6);
      k_gnt   = ($urandom_range(99) < 70);
      k_reset = ($urandom_range(999) < 5);
      if ($urandom_range(9) == 0) k_rpc = 32'hFFFF_FFF0 | $urandom_range(15);
      else                        k_rpc = $urandom & 32'h0000_0FFF;
      step();
    end
    k_reset = 1'b0; k_stall = 1'b0; k_redir = 1'b0; k_gnt = 1'b1;
    repeat (10) step();
    chk("progress", {31'd0, (nvalid > 100)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
